layer_address_sequencer: RTL and testbench

LAYER_ADDRESS_SEQUENCER -- requirements
Module: layer_address_sequencer

---
 rtl/layer_addr_pkg.sv | 13 +
 rtl/layer_address_sequencer_if.sv | 43 ++++
 rtl/loop_counter.sv | 29 ++
 rtl/layer_address_sequencer.sv | 125 ++++++++++++
 tb/tb_layer_address_sequencer.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/layer_addr_pkg.sv
// Shared types and default widths for the layer address sequencer.
package layer_addr_pkg;

  localparam int ADDR_W_DEFAULT = 8;
  localparam int CNT_W_DEFAULT  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/layer_address_sequencer_if.sv
// Configuration, address handshake and status bundle of the layer address sequencer.
interface layer_address_sequencer_if
  import layer_addr_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int CNT_W  = CNT_W_DEFAULT
);

  logic              start;
  logic [CNT_W-1:0]  Nk;
  logic [CNT_W-1:0]  Nn;
  logic              bias_en;
  logic [ADDR_W-1:0] read_weight_base_addr;
  logic [ADDR_W-1:0] read_neuro_base_addr;
  logic [ADDR_W-1:0] write_neuro_base_addr;

  logic              addr_ready;
  logic              addr_valid;
  logic [ADDR_W-1:0] weight_read_addr;
  logic [ADDR_W-1:0] neuro_read_addr;
  logic              bias_beat;
  logic              neuron_finished;
  logic [ADDR_W-1:0] neuro_write_addr;
  logic              busy;
  logic              finished;

  modport master (
    output start, Nk, Nn, bias_en,
    output read_weight_base_addr, read_neuro_base_addr, write_neuro_base_addr,
    output addr_ready,
    input  addr_valid, weight_read_addr, neuro_read_addr, bias_beat,
    input  neuron_finished, neuro_write_addr, busy, finished
  );

  modport slave (
    input  start, Nk, Nn, bias_en,
    input  read_weight_base_addr, read_neuro_base_addr, write_neuro_base_addr,
    input  addr_ready,
    output addr_valid, weight_read_addr, neuro_read_addr, bias_beat,
    output neuron_finished, neuro_write_addr, busy, finished
  );

endinterface

// File: rtl/loop_counter.sv
// Purpose: enabled up-counter wrapping to zero after limit-1, with a last-value flag.
// Latency: count updates on the edge after en; last is a combinational decode of count.
// Backpressure: none of its own; the parent gates en with its handshake.
module loop_counter #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         last
);

  assign last = (count == (limit - W'(1)));

  // clr wins over en so a new pass always starts from zero
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= last ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/layer_address_sequencer.sv
// Purpose: walks weight/input-neuron read addresses and output-neuron write addresses for one layer.
// Latency: first beat in the cycle after start is sampled; finished one cycle after the last beat.
// Backpressure: addr_ready=0 freezes every output and all internal state.
module layer_address_sequencer
  import layer_addr_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int CNT_W  = CNT_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  layer_address_sequencer_if.slave bus
);

  // One extra bit so Nk + bias_en = 2^CNT_W still fits
  localparam int CW = CNT_W + 1;

  state_t            state;
  logic [CW-1:0]     nk_q;
  logic [CW-1:0]     beats_q;
  logic [CW-1:0]     nn_q;
  logic              bias_q;
  logic [ADDR_W-1:0] rbase_q;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] wr_addr;

  logic [CW-1:0]     nk_in;
  logic [CW-1:0]     nn_in;
  logic [CW-1:0]     beats_in;
  logic              load;
  logic              accept;
  logic [CW-1:0]     beat_cnt;
  logic [CW-1:0]     neuron_cnt;
  logic              beat_last;
  logic              neuron_last;

  assign nk_in    = {1'b0, bus.Nk};
  assign nn_in    = {1'b0, bus.Nn};
  assign beats_in = nk_in + CW'(bus.bias_en);
  assign load     = (state == IDLE) && bus.start;
  assign accept   = (state == RUN) && bus.addr_ready;

  loop_counter #(.W(CW)) u_beat_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (load),
    .en    (accept),
    .limit (beats_q),
    .count (beat_cnt),
    .last  (beat_last)
  );

  loop_counter #(.W(CW)) u_neuron_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (load),
    .en    (accept && beat_last),
    .limit (nn_q),
    .count (neuron_cnt),
    .last  (neuron_last)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      nk_q    <= '0;
      beats_q <= '0;
      nn_q    <= '0;
      bias_q  <= 1'b0;
      rbase_q <= '0;
      w_addr  <= '0;
      r_addr  <= '0;
      wr_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            nk_q    <= nk_in;
            beats_q <= beats_in;
            nn_q    <= nn_in;
            bias_q  <= bus.bias_en;
            rbase_q <= bus.read_neuro_base_addr;
            w_addr  <= bus.read_weight_base_addr;
            r_addr  <= bus.read_neuro_base_addr;
            wr_addr <= bus.write_neuro_base_addr;
            state   <= ((bus.Nk == '0) || (bus.Nn == '0)) ? DONE : RUN;
          end
        end
        RUN: begin
          if (bus.addr_ready) begin
            // Weights are laid out densely, so the weight pointer simply runs on
            w_addr <= w_addr + ADDR_W'(1);
            if (beat_last) begin
              r_addr <= rbase_q;
              if (neuron_last) begin
                state <= DONE;
              end else begin
                wr_addr <= wr_addr + ADDR_W'(1);
              end
            end else begin
              r_addr <= r_addr + ADDR_W'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.addr_valid       = (state == RUN);
  assign bus.busy             = (state != IDLE);
  assign bus.finished         = (state == DONE);
  assign bus.weight_read_addr = w_addr;
  assign bus.neuro_read_addr  = r_addr;
  assign bus.neuro_write_addr = wr_addr;
  assign bus.bias_beat        = (state == RUN) && bias_q && (beat_cnt == nk_q);
  assign bus.neuron_finished  = (state == RUN) && beat_last;

endmodule

// File: tb/tb_layer_address_sequencer.sv
// Bench for layer_address_sequencer: directed vector table, hand sequences, and random passes against a beat-list model.
module tb_layer_address_sequencer;
  import layer_addr_pkg::*;

  localparam int AW  = 8;
  localparam int CW  = 8;
  localparam int MOD = 1 << AW;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  layer_address_sequencer_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();

  layer_address_sequencer #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int w;
    int n;
    bit bias;
    bit fin;
    int wr;
  } beat_t;

  typedef struct {
    int nk;
    int nn;
    bit b;
    int wb;
    int rb;
    int wrb;
    int beats;
    int first_w;
    int last_w;
    int last_wr;
    int bias_cnt;
  } vec_t;

  beat_t exp_q[$];
  vec_t  tbl[9];
  int obs_beats, obs_first_w, obs_last_w, obs_last_wr, obs_bias, obs_hold, obs_cycles;

  // Expected beat list straight from the addressing rules
  task automatic build_model(input int nk, input int nn, input bit b,
                             input int wb, input int rb, input int wrb);
    int    bpn;
    beat_t e;
    exp_q.delete();
    bpn = nk + int'(b);
    if (nk == 0 || nn == 0) return;
    for (int j = 0; j < nn; j++) begin
      for (int i = 0; i < bpn; i++) begin
        e.w    = (wb + j * bpn + i) % MOD;
        e.n    = (rb + i) % MOD;
        e.bias = (i == nk);
        e.fin  = (i == bpn - 1);
        e.wr   = (wrb + j) % MOD;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic scramble();
    bus.Nk                    = CW'($urandom);
    bus.Nn                    = CW'($urandom);
    bus.bias_en               = 1'($urandom);
    bus.read_weight_base_addr = AW'($urandom);
    bus.read_neuro_base_addr  = AW'($urandom);
    bus.write_neuro_base_addr = AW'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr_valid"},       int'(bus.addr_valid), 0);
    check({tag, "_weight_read_addr"}, int'(bus.weight_read_addr), 0);
    check({tag, "_neuro_read_addr"},  int'(bus.neuro_read_addr), 0);
    check({tag, "_bias_beat"},        int'(bus.bias_beat), 0);
    check({tag, "_neuron_finished"},  int'(bus.neuron_finished), 0);
    check({tag, "_neuro_write_addr"}, int'(bus.neuro_write_addr), 0);
    check({tag, "_busy"},             int'(bus.busy), 0);
    check({tag, "_finished"},         int'(bus.finished), 0);
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready low 3 cycles while beat index 1 is shown
  // Entered and left at posedge+1 with the DUT in IDLE.
  task automatic run_pass(input int nk, input int nn, input bit b,
                          input int wb, input int rb, input int wrb,
                          input int mode, input bit noise);
    int    cycles, accepted, stall_left;
    bit    done;
    beat_t e;
    build_model(nk, nn, b, wb, rb, wrb);
    obs_beats = 0; obs_first_w = -1; obs_last_w = -1; obs_last_wr = -1;
    obs_bias = 0; obs_hold = 0;
    bus.Nk = CW'(nk); bus.Nn = CW'(nn); bus.bias_en = b;
    bus.read_weight_base_addr = AW'(wb);
    bus.read_neuro_base_addr  = AW'(rb);
    bus.write_neuro_base_addr = AW'(wrb);
    bus.start = 1'b1;
    bus.addr_ready = 1'b1;
    @(posedge clk); #1;
    accepted = 0; stall_left = 3; cycles = 0; done = 1'b0;
    while (!done && cycles < 5000) begin
      if (noise) begin
        scramble();
        bus.start = (exp_q.size() == 0) ? 1'b1 : 1'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      case (mode)
        1:       bus.addr_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (accepted == 1 && stall_left > 0) begin
            bus.addr_ready = 1'b0;
            stall_left--;
          end else begin
            bus.addr_ready = 1'b1;
          end
        end
        default: bus.addr_ready = 1'b1;
      endcase
      @(negedge clk);
      if (exp_q.size() == 0) begin
        check("finished_pulse", int'(bus.finished), 1);
        check("valid_in_done",  int'(bus.addr_valid), 0);
        check("busy_in_done",   int'(bus.busy), 1);
        done = 1'b1;
      end else begin
        e = exp_q[0];
        check("addr_valid",       int'(bus.addr_valid), 1);
        check("busy_in_run",      int'(bus.busy), 1);
        check("finished_in_run",  int'(bus.finished), 0);
        check("weight_read_addr", int'(bus.weight_read_addr), e.w);
        check("bias_beat",        int'(bus.bias_beat), int'(e.bias));
        if (!e.bias) check("neuro_read_addr", int'(bus.neuro_read_addr), e.n);
        check("neuron_finished",  int'(bus.neuron_finished), int'(e.fin));
        if (e.fin) check("neuro_write_addr", int'(bus.neuro_write_addr), e.wr);
        if (accepted == 1) obs_hold++;
        if (bus.addr_ready) begin
          if (obs_first_w < 0) obs_first_w = int'(bus.weight_read_addr);
          obs_last_w = int'(bus.weight_read_addr);
          if (bus.neuron_finished) obs_last_wr = int'(bus.neuro_write_addr);
          if (bus.bias_beat) obs_bias++;
          obs_beats++;
          accepted++;
          void'(exp_q.pop_front());
        end
      end
      @(posedge clk); #1;
      cycles++;
    end
    obs_cycles = cycles;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL pass_timeout: got %0d cycles without finished, expected completion", cycles);
    end
    // start was high during DONE; it must not have restarted the pass
    bus.start = 1'b0;
    bus.addr_ready = 1'b1;
    @(negedge clk);
    check("idle_after_done_busy",     int'(bus.busy), 0);
    check("idle_after_done_valid",    int'(bus.addr_valid), 0);
    check("idle_after_done_finished", int'(bus.finished), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    tbl[0] = '{3, 2, 1'b0,   1,  2,   3,   6,   1,   6,  4, 0};
    tbl[1] = '{3, 2, 1'b1,   1,  2,   3,   8,   1,   8,  4, 2};
    tbl[2] = '{2, 2, 1'b0, 254,  0,   0,   4, 254,   1,  1, 0};
    tbl[3] = '{1, 1, 1'b1,  10, 20,  30,   2,  10,  11, 30, 1};
    tbl[4] = '{4, 3, 1'b0, 250,  7, 255,  12, 250,   5,  1, 0};
    tbl[5] = '{5, 0, 1'b0,   9,  9,   9,   0,   0,   0,  0, 0};
    tbl[6] = '{0, 3, 1'b1,   9,  9,   9,   0,   0,   0,  0, 0};
    tbl[7] = '{255, 1, 1'b1, 0,  0,   0, 256,   0, 255,  0, 1};
    tbl[8] = '{1, 3, 1'b0, 100, 50, 254,   3, 100, 102,  0, 0};

    // Reset holds everything at zero even with start asserted
    bus.Nk = CW'(3); bus.Nn = CW'(2); bus.bias_en = 1'b0;
    bus.read_weight_base_addr = AW'(1);
    bus.read_neuro_base_addr  = AW'(2);
    bus.write_neuro_base_addr = AW'(3);
    bus.start = 1'b1;
    bus.addr_ready = 1'b1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    bus.start = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[k]) begin
      run_pass(tbl[k].nk, tbl[k].nn, tbl[k].b, tbl[k].wb, tbl[k].rb, tbl[k].wrb, 0, 1'b0);
      check($sformatf("vec%0d_beats", k), obs_beats, tbl[k].beats);
      check($sformatf("vec%0d_cycles", k), obs_cycles, tbl[k].beats + 1);
      if (tbl[k].beats > 0) begin
        check($sformatf("vec%0d_first_w", k),  obs_first_w, tbl[k].first_w);
        check($sformatf("vec%0d_last_w", k),   obs_last_w,  tbl[k].last_w);
        check($sformatf("vec%0d_last_wr", k),  obs_last_wr, tbl[k].last_wr);
        check($sformatf("vec%0d_bias_cnt", k), obs_bias,    tbl[k].bias_cnt);
      end
    end

    // Three-cycle stall on the second beat
    run_pass(3, 2, 1'b0, 1, 2, 3, 2, 1'b0);
    check("stall_hold_cycles", obs_hold, 4);
    check("stall_beats", obs_beats, 6);
    check("stall_last_w", obs_last_w, 6);
    check("stall_cycles", obs_cycles, 6 + 3 + 1);

    // Reset while the third beat is on the bus
    bus.Nk = CW'(3); bus.Nn = CW'(2); bus.bias_en = 1'b0;
    bus.read_weight_base_addr = AW'(1);
    bus.read_neuro_base_addr  = AW'(2);
    bus.write_neuro_base_addr = AW'(3);
    bus.start = 1'b1;
    bus.addr_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("midreset_pre_w", int'(bus.weight_read_addr), 3);
    reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("midreset");
    @(posedge clk); #1;
    @(negedge clk);
    check("midreset_no_finished", int'(bus.finished), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    run_pass(3, 2, 1'b0, 1, 2, 3, 0, 1'b0);
    check("after_reset_first_w", obs_first_w, 1);
    check("after_reset_beats", obs_beats, 6);

    // Random configurations, random ready, inputs and start churning during the pass
    for (int r = 0; r < 30; r++) begin
      run_pass($urandom_range(0, 6), $urandom_range(0, 4), 1'($urandom),
               $urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1),
               $urandom_range(0, MOD - 1), $urandom_range(0, 1), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
